// File: rtl/uart_reg_responder_if.sv
// uart_reg_responder_if: UART byte handshake and register bus
// bundle between the command responder and its surroundings.
interface uart_reg_responder_if;
  logic [7:0] rx_data_i;
  logic       rx_ready_i;
  logic       rx_ack_o;
  logic       rx_error_i;
  logic [7:0] tx_data_o;
  logic       tx_ready_o;
  logic       tx_ack_i;
  logic [2:0] reg_addr_o;
  logic [7:0] reg_wdata_o;
  logic       reg_we_o;
  logic       reg_re_o;
  logic [7:0] reg_rdata_i;
  logic       busy_o;
  logic       link_error_o;

  modport slave (
    input  rx_data_i,
    input  rx_ready_i,
    output rx_ack_o,
    input  rx_error_i,
    output tx_data_o,
    output tx_ready_o,
    input  tx_ack_i,
    output reg_addr_o,
    output reg_wdata_o,
    output reg_we_o,
    output reg_re_o,
    input  reg_rdata_i,
    output busy_o,
    output link_error_o
  );

  modport master (
    output rx_data_i,
    output rx_ready_i,
    input  rx_ack_o,
    output rx_error_i,
    input  tx_data_o,
    input  tx_ready_o,
    output tx_ack_i,
    input  reg_addr_o,
    input  reg_wdata_o,
    input  reg_we_o,
    input  reg_re_o,
    output reg_rdata_i,
    input  busy_o,
    input  link_error_o
  );
endinterface

// File: rtl/uart_reg_responder.sv
// uart_reg_responder: decodes UART octets into single register
// read/write commands and answers each with one response octet.
module uart_reg_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  uart_reg_responder_if.slave  bus
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] RESP_OK  = 8'hA5;
  localparam logic [7:0] RESP_ERR = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_DATA,
    S_EXEC,
    S_SEND,
    S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    resp_q, resp_d;
  logic          write_q, write_d;
  logic          halt_q, halt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rx_ack;
  logic          cmd_bad;

  assign cmd_bad = |bus.rx_data_i[6:3];

  assign rx_ack = reset_n && bus.rx_ready_i && !bus.rx_error_i &&
                  (state_q == S_IDLE || state_q == S_GET_DATA);

  // State register and command datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      write_q <= 1'b0;
      halt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      write_q <= write_d;
      halt_q  <= halt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath load decisions.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    resp_d  = resp_q;
    write_d = write_q;
    halt_d  = halt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.rx_error_i) begin
          resp_d  = RESP_ERR;
          halt_d  = 1'b1;
          state_d = S_SEND;
        end else if (rx_ack) begin
          if (cmd_bad) begin
            resp_d  = RESP_ERR;
            state_d = S_SEND;
          end else begin
            addr_d  = bus.rx_data_i[2:0];
            write_d = bus.rx_data_i[7];
            if (bus.rx_data_i[7]) begin
              cnt_d   = '0;
              state_d = S_GET_DATA;
            end else begin
              state_d = S_EXEC;
            end
          end
        end
      end
      S_GET_DATA: begin
        if (bus.rx_error_i) begin
          resp_d  = RESP_ERR;
          halt_d  = 1'b1;
          state_d = S_SEND;
        end else if (rx_ack) begin
          wdata_d = bus.rx_data_i;
          state_d = S_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EXEC: begin
        resp_d  = write_q ? RESP_OK : bus.reg_rdata_i;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (bus.tx_ack_i) begin
          state_d = halt_q ? S_HALT : S_IDLE;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.rx_ack_o     = rx_ack;
  assign bus.tx_data_o    = resp_q;
  assign bus.tx_ready_o   = reset_n && (state_q == S_SEND);
  assign bus.reg_addr_o   = addr_q;
  assign bus.reg_wdata_o  = wdata_q;
  assign bus.reg_we_o     = reset_n && (state_q == S_EXEC) && write_q;
  assign bus.reg_re_o     = reset_n && (state_q == S_EXEC) && !write_q;
  assign bus.busy_o       = reset_n && (state_q != S_IDLE) &&
                            (state_q != S_HALT);
  assign bus.link_error_o = reset_n && (state_q == S_HALT);

endmodule
